// File: rtl/icache_fetch_port_pkg.sv
// Shared constants and FSM state type for the instruction-cache fetch port.
package icache_fetch_port_pkg;
  localparam int unsigned IC_DAT_W     = 32;
  localparam int unsigned IC_RAM_ADR_W = 17;
  localparam int unsigned ICACHE_IDX_W = 6;

  typedef enum logic {
    ICS_IDLE = 1'b0,
    ICS_MISS = 1'b1
  } ics_state_e;
endpackage

// File: rtl/icache_fetch_port_store.sv
// Direct-mapped line storage: one synchronous write port, one combinational read port.
module icache_store
  import icache_fetch_port_pkg::*;
#(
  parameter int unsigned IDX_W = ICACHE_IDX_W,
  parameter int unsigned TAG_W = IC_RAM_ADR_W - ICACHE_IDX_W - 2,
  parameter int unsigned DAT_W = IC_DAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [IDX_W-1:0] widx_i,
  input  logic [TAG_W-1:0] wtag_i,
  input  logic [DAT_W-1:0] wdata_i,
  input  logic [IDX_W-1:0] ridx_i,
  input  logic [TAG_W-1:0] rtag_i,
  output logic             hit_o,
  output logic [DAT_W-1:0] rdata_o
);
  localparam int unsigned LINES = 1 << IDX_W;

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [DAT_W-1:0] data_q [LINES];

  always_comb begin
    valid_d = valid_q;
    if (we_i) valid_d[widx_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag/data need no reset: a line is only consulted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[widx_i]  <= wtag_i;
      data_q[widx_i] <= wdata_i;
    end
  end

  assign hit_o   = valid_q[ridx_i] && (tag_q[ridx_i] == rtag_i);
  assign rdata_o = data_q[ridx_i];
endmodule

// File: rtl/icache_fetch_port.sv
// Instruction-cache fetch port: serves hits in one cycle, fills misses over the IC protocol.
module icache_fetch_port
  import icache_fetch_port_pkg::*;
#(
  parameter int unsigned ADR_W = IC_RAM_ADR_W,
  parameter int unsigned DAT_W = IC_DAT_W,
  parameter int unsigned IDX_W = ICACHE_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             if_en_i,
  input  logic [ADR_W-1:0] if_pc_i,
  output logic             if_en_o,
  output logic [DAT_W-1:0] if_ins_o,
  output logic             mc_en_o,
  output logic [ADR_W-1:0] mc_pc_o,
  input  logic             mc_en_i,
  input  logic [DAT_W-1:0] mc_ins_i,
  input  logic             br_flag
);
  localparam int unsigned TAG_W = ADR_W - IDX_W - 2;

  ics_state_e       state_q, state_d;
  logic             if_en_q, if_en_d;
  logic [DAT_W-1:0] if_ins_q, if_ins_d;
  logic             mc_en_q, mc_en_d;
  logic [ADR_W-1:0] mc_pc_q, mc_pc_d;

  logic             hit;
  logic [DAT_W-1:0] rdata;
  logic             fill;
  logic             unused_pc_lsb;

  assign unused_pc_lsb = ^if_pc_i[1:0];

  // A fill still lands when br_flag aborts the request in the same cycle.
  assign fill = !rst && en && (state_q == ICS_MISS) && mc_en_i;

  icache_store #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W),
    .DAT_W (DAT_W)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .we_i    (fill),
    .widx_i  (mc_pc_q[IDX_W+1:2]),
    .wtag_i  (mc_pc_q[ADR_W-1:IDX_W+2]),
    .wdata_i (mc_ins_i),
    .ridx_i  (if_pc_i[IDX_W+1:2]),
    .rtag_i  (if_pc_i[ADR_W-1:IDX_W+2]),
    .hit_o   (hit),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d  = state_q;
    if_en_d  = 1'b0;
    if_ins_d = if_ins_q;
    mc_en_d  = 1'b0;
    mc_pc_d  = mc_pc_q;
    if (!en) begin
      state_d = state_q;
    end else if (br_flag) begin
      state_d = ICS_IDLE;
    end else begin
      case (state_q)
        ICS_IDLE: begin
          if (if_en_i) begin
            if (hit) begin
              if_en_d  = 1'b1;
              if_ins_d = rdata;
            end else begin
              mc_en_d = 1'b1;
              mc_pc_d = {if_pc_i[ADR_W-1:2], 2'b00};
              state_d = ICS_MISS;
            end
          end
        end
        ICS_MISS: begin
          if (mc_en_i) begin
            if_en_d  = 1'b1;
            if_ins_d = mc_ins_i;
            state_d  = ICS_IDLE;
          end
        end
        default: state_d = ICS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ICS_IDLE;
      if_en_q  <= 1'b0;
      if_ins_q <= '0;
      mc_en_q  <= 1'b0;
      mc_pc_q  <= '0;
    end else begin
      state_q  <= state_d;
      if_en_q  <= if_en_d;
      if_ins_q <= if_ins_d;
      mc_en_q  <= mc_en_d;
      mc_pc_q  <= mc_pc_d;
    end
  end

  // The fetcher keeps at most one request outstanding.
  a_no_fetch_in_miss: assert property (@(posedge clk) disable iff (rst)
    !(en && !br_flag && (state_q == ICS_MISS) && if_en_i))
    else $error("if_en_i asserted while a miss is outstanding");

  assign if_en_o  = if_en_q;
  assign if_ins_o = if_ins_q;
  assign mc_en_o  = mc_en_q;
  assign mc_pc_o  = mc_pc_q;
endmodule

// File: tb/tb_icache_fetch_port.sv
// Self-checking bench for icache_fetch_port: vector table, directed corner cases, random vs. model.
module tb_icache_fetch_port;
  logic        clk = 1'b0;
  logic        rst, en, if_en_i, mc_en_i, br_flag;
  logic [16:0] if_pc_i;
  logic [31:0] mc_ins_i;
  logic        if_en_o, mc_en_o;
  logic [31:0] if_ins_o;
  logic [16:0] mc_pc_o;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  icache_fetch_port #(.ADR_W(17), .DAT_W(32), .IDX_W(6)) dut (
    .clk(clk), .rst(rst), .en(en), .if_en_i(if_en_i), .if_pc_i(if_pc_i),
    .if_en_o(if_en_o), .if_ins_o(if_ins_o), .mc_en_o(mc_en_o), .mc_pc_o(mc_pc_o),
    .mc_en_i(mc_en_i), .mc_ins_i(mc_ins_i), .br_flag(br_flag)
  );

  typedef struct {
    logic        rst, en, if_en;
    logic [16:0] pc;
    logic        mc_en;
    logic [31:0] ins;
    logic        br;
    logic        x_if_en;
    logic [31:0] x_ins;
    logic        x_mc_en;
    logic [16:0] x_mc_pc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic e, logic fi, logic [16:0] pc, logic me,
                              logic [31:0] d, logic b, logic xif, logic [31:0] xins,
                              logic xmc, logic [16:0] xpc);
    vec_t v;
    v.rst = r; v.en = e; v.if_en = fi; v.pc = pc; v.mc_en = me; v.ins = d; v.br = b;
    v.x_if_en = xif; v.x_ins = xins; v.x_mc_en = xmc; v.x_mc_pc = xpc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Apply inputs for one cycle, let the edge pass, then compare registered outputs.
  task automatic cyc(input logic r, input logic e, input logic fi, input logic [16:0] pc,
                     input logic me, input logic [31:0] d, input logic b,
                     input logic xif, input logic [31:0] xins, input logic xmc,
                     input logic [16:0] xpc, input string nm);
    rst = r; en = e; if_en_i = fi; if_pc_i = pc; mc_en_i = me; mc_ins_i = d; br_flag = b;
    @(posedge clk);
    #1;
    chk({nm, ".if_en_o"},  {31'd0, if_en_o}, {31'd0, xif});
    chk({nm, ".if_ins_o"}, if_ins_o, xins);
    chk({nm, ".mc_en_o"},  {31'd0, mc_en_o}, {31'd0, xmc});
    chk({nm, ".mc_pc_o"},  {15'd0, mc_pc_o}, {15'd0, xpc});
  endtask

  bit          vld [64];
  logic [14:0] maddr [64];
  logic [31:0] mdat [64];

  initial begin
    rst = 1'b1; en = 1'b1; if_en_i = 1'b0; if_pc_i = '0;
    mc_en_i = 1'b0; mc_ins_i = '0; br_flag = 1'b0;

    // Basic miss with 6-cycle controller, hit, back-to-back, conflict miss.
    tbl.push_back(mk(1,1,0,17'h0,    0,32'h0,       0, 0,32'h0,       0,17'h0));
    tbl.push_back(mk(0,1,1,17'h10,   0,32'h0,       0, 0,32'h0,       1,17'h10));
    for (int unsigned i = 0; i < 5; i++)
      tbl.push_back(mk(0,1,0,17'h0,  0,32'h0,       0, 0,32'h0,       0,17'h10));
    tbl.push_back(mk(0,1,0,17'h0,    1,32'h00500093,0, 1,32'h00500093,0,17'h10));
    tbl.push_back(mk(0,1,1,17'h10,   0,32'h0,       0, 1,32'h00500093,0,17'h10));
    tbl.push_back(mk(0,1,0,17'h0,    0,32'h0,       0, 0,32'h00500093,0,17'h10));
    tbl.push_back(mk(0,1,1,17'h110,  0,32'h0,       0, 0,32'h00500093,1,17'h110));
    tbl.push_back(mk(0,1,0,17'h0,    1,32'hAAAA0001,0, 1,32'hAAAA0001,0,17'h110));
    tbl.push_back(mk(0,1,1,17'h10,   0,32'h0,       0, 0,32'hAAAA0001,1,17'h10));
    tbl.push_back(mk(0,1,0,17'h0,    1,32'h00500093,0, 1,32'h00500093,0,17'h10));

    foreach (tbl[i])
      cyc(tbl[i].rst, tbl[i].en, tbl[i].if_en, tbl[i].pc, tbl[i].mc_en, tbl[i].ins,
          tbl[i].br, tbl[i].x_if_en, tbl[i].x_ins, tbl[i].x_mc_en, tbl[i].x_mc_pc,
          $sformatf("tbl%0d", i));

    // Branch flush two cycles into a miss, then an immediate new miss.
    cyc(0,1,1,17'h20,0,32'h0,       0, 0,32'h00500093,1,17'h20,"A_req");
    cyc(0,1,0,17'h0, 0,32'h0,       0, 0,32'h00500093,0,17'h20,"A_wait");
    cyc(0,1,0,17'h0, 0,32'h0,       1, 0,32'h00500093,0,17'h20,"A_br");
    cyc(0,1,1,17'h40,0,32'h0,       0, 0,32'h00500093,1,17'h40,"A_next");
    cyc(0,1,0,17'h0, 1,32'h11111111,0, 1,32'h11111111,0,17'h40,"A_fill");

    // Flush coinciding with the fill: line written but not returned.
    cyc(0,1,1,17'h30,0,32'h0,       0, 0,32'h11111111,1,17'h30,"B_req");
    cyc(0,1,0,17'h0, 1,32'h13,      1, 0,32'h11111111,0,17'h30,"B_brfill");
    cyc(0,1,1,17'h30,0,32'h0,       0, 1,32'h13,      0,17'h30,"B_hit");

    // Stall around a hit request: deferred, never duplicated.
    for (int unsigned i = 0; i < 3; i++)
      cyc(0,0,1,17'h10,0,32'h0,     0, 0,32'h13,      0,17'h30,"C_stall");
    cyc(0,1,1,17'h10,0,32'h0,       0, 1,32'h00500093,0,17'h30,"C_go");
    cyc(0,0,1,17'h10,0,32'h0,       0, 0,32'h00500093,0,17'h30,"C_stall2");
    cyc(0,1,0,17'h0, 0,32'h0,       0, 0,32'h00500093,0,17'h30,"C_idle");

    // Reset in the middle of a miss invalidates everything.
    cyc(0,1,1,17'h110,0,32'h0,      0, 0,32'h00500093,1,17'h110,"D_req");
    cyc(0,1,0,17'h0, 0,32'h0,       0, 0,32'h00500093,0,17'h110,"D_wait");
    cyc(1,1,0,17'h0, 0,32'h0,       0, 0,32'h0,       0,17'h0, "D_rst");
    cyc(0,1,1,17'h30,0,32'h0,       0, 0,32'h0,       1,17'h30,"D_remiss");
    cyc(0,1,0,17'h0, 1,32'h13,      0, 1,32'h13,      0,17'h30,"D_fill");

    // Randomised traffic against a word-address cache model and a responder with random latency.
    begin
      bit          outst = 0;
      int          cnt = 0;
      logic [16:0] opc = '0;
      logic [31:0] xins = '0;
      logic [16:0] xpc = '0;
      for (int c = 0; c < 800; c++) begin
        logic        r, e, b, fi, done, xif, xmc;
        logic [16:0] pc;
        logic [31:0] d;
        int unsigned idx;
        r    = (c == 0) || ($urandom_range(0, 63) == 0);
        done = (cnt == 1);
        e    = done ? 1'b1 : ($urandom_range(0, 7) != 0);
        b    = ($urandom_range(0, 11) == 0);
        fi   = !outst && ($urandom_range(0, 1) == 1);
        pc   = 17'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
        d    = $urandom;
        xif  = 0;
        xmc  = 0;
        if (r) begin
          foreach (vld[k]) vld[k] = 0;
          outst = 0; xins = '0; xpc = '0;
        end else if (e) begin
          if (outst && done) begin
            idx = 32'(opc[7:2]);
            vld[idx] = 1; maddr[idx] = opc[16:2]; mdat[idx] = d;
            if (!b) begin xif = 1; xins = d; end
            outst = 0;
          end else if (b) begin
            outst = 0;
          end else if (!outst && fi) begin
            idx = 32'(pc[7:2]);
            if (vld[idx] && maddr[idx] == pc[16:2]) begin
              xif = 1; xins = mdat[idx];
            end else begin
              xmc = 1; xpc = {pc[16:2], 2'b00}; opc = xpc; outst = 1;
            end
          end
        end
        cyc(r, e, fi, pc, done, d, b, xif, xins, xmc, xpc, $sformatf("rnd%0d", c));
        if (r || (e && b)) cnt = 0;
        else if (cnt > 0)  cnt--;
        if (xmc) cnt = $urandom_range(1, 4);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
